// File: rtl/rr_bus_arbiter8_pkg.sv
// rtl/rr_bus_arbiter8_pkg.sv - shared sizes, state encoding and helpers for the 8-way bus arbiter
package rr_bus_arbiter8_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    idx_to_onehot = N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_bus_arbiter8_pick8.sv
// rtl/rr_bus_arbiter8_pick8.sv - rr_pick8: combinational rotating-priority picker, ptr has top priority
module rr_pick8
  import rr_bus_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] req_masked,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk offsets from farthest to nearest so the candidate closest to ptr is the last one kept.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req_masked[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter8.sv
// rtl/rr_bus_arbiter8.sv - round-robin arbiter steering one of 8 requester words onto a valid/ready bus
// Optional burst locking is enabled by defining ARB_LOCK_EN.
module rr_bus_arbiter8
  import rr_bus_arbiter8_pkg::*;
#(
  parameter int WIDTH = 16
`ifdef ARB_LOCK_EN
  , parameter int MAX_BURST = 4
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data_in,
`ifdef ARB_LOCK_EN
  input  logic [N_REQ-1:0]       lock,
`endif
  input  logic                   out_ready,
  output logic [N_REQ-1:0]       grant,
  output logic [SEL_W-1:0]       sel,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [N_REQ-1:0]       ack,
  output logic                   busy
);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
`ifdef ARB_LOCK_EN
  logic [7:0]       burst_cnt_q, burst_cnt_d;
`endif

  logic             xfer;
  logic             keep;
  logic [N_REQ-1:0] pick_req;
  logic [SEL_W-1:0] pick_ptr;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;

  // A reset cycle never counts as a transfer, so a grant dropped by reset produces no ack.
  always_comb begin
    xfer     = valid_q & out_ready & ~reset;
    keep     = 1'b0;
`ifdef ARB_LOCK_EN
    keep     = xfer & lock[sel_q] & (burst_cnt_q < 8'(MAX_BURST - 1));
`endif
    pick_req = req;
    pick_ptr = ptr_q;
    if (state_q == ST_BUSY && xfer) begin
      pick_req = req & ~grant_q;
      pick_ptr = sel_q + SEL_W'(1);
    end
  end

  rr_pick8 u_pick (
    .req_masked (pick_req),
    .ptr        (pick_ptr),
    .any        (pick_any),
    .idx        (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    valid_d     = valid_q;
    ptr_d       = ptr_q;
`ifdef ARB_LOCK_EN
    burst_cnt_d = burst_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_BUSY;
          sel_d   = pick_idx;
          grant_d = idx_to_onehot(pick_idx);
          valid_d = 1'b1;
        end
      end
      ST_BUSY: begin
        if (xfer) begin
          if (keep) begin
`ifdef ARB_LOCK_EN
            burst_cnt_d = burst_cnt_q + 8'd1;
`endif
          end else begin
`ifdef ARB_LOCK_EN
            burst_cnt_d = '0;
`endif
            ptr_d = sel_q + SEL_W'(1);
            if (pick_any) begin
              sel_d   = pick_idx;
              grant_d = idx_to_onehot(pick_idx);
            end else begin
              state_d = ST_IDLE;
              grant_d = '0;
              valid_d = 1'b0;
            end
          end
        end else if (!req[sel_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
          valid_d = 1'b0;
`ifdef ARB_LOCK_EN
          burst_cnt_d = '0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      sel_q       <= '0;
      valid_q     <= 1'b0;
      ptr_q       <= '0;
`ifdef ARB_LOCK_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      valid_q     <= valid_d;
      ptr_q       <= ptr_d;
`ifdef ARB_LOCK_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign out_valid = valid_q;
  assign out_data  = data_in[int'(sel_q) * WIDTH +: WIDTH];
  assign ack       = grant_q & {N_REQ{xfer}};
  assign busy      = (state_q == ST_BUSY);

endmodule

// File: tb/tb_rr_bus_arbiter8.sv
// tb/tb_rr_bus_arbiter8.sv - directed vector bench for rr_bus_arbiter8
module tb_rr_bus_arbiter8;

  localparam int WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [7:0]           req;
  logic [8*WIDTH-1:0]   data_in;
`ifdef ARB_LOCK_EN
  logic [7:0]           lock;
`endif
  logic                 out_ready;
  logic [7:0]           grant;
  logic [2:0]           sel;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [7:0]           ack;
  logic                 busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_bus_arbiter8 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data_in   (data_in),
`ifdef ARB_LOCK_EN
    .lock      (lock),
`endif
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .ack       (ack),
    .busy      (busy)
  );

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rdy;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic [7:0] ack;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] word(input int i);
    return 16'hC000 | 16'(i * 16'h0111);
  endfunction

  task automatic add(input logic rst, input logic [7:0] rq, input logic rdy, input logic [7:0] eg,
                     input logic [2:0] es, input logic ev, input logic [7:0] ea, input logic eb);
    vec_t v;
    v.rst = rst; v.req = rq; v.rdy = rdy;
    v.grant = eg; v.sel = es; v.valid = ev; v.ack = ea; v.busy = eb;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] eg, input logic [2:0] es,
                            input logic ev, input logic [7:0] ea, input logic eb);
    check({tag, " grant"}, 32'(grant), 32'(eg));
    check({tag, " sel"}, 32'(sel), 32'(es));
    check({tag, " out_valid"}, 32'(out_valid), 32'(ev));
    check({tag, " ack"}, 32'(ack), 32'(ea));
    check({tag, " busy"}, 32'(busy), 32'(eb));
    if (ev) check({tag, " out_data"}, 32'(out_data), 32'(word(int'(es))));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int exp_owner[10];

  initial begin
    for (int i = 0; i < 8; i++) data_in[i*WIDTH +: WIDTH] = word(i);
    reset = 1'b1; req = 8'hFF; out_ready = 1'b1;
`ifdef ARB_LOCK_EN
    lock = 8'h00;
`endif

    //   rst  req    rdy  grant  sel   v     ack    busy
    add(1'b1, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
    add(1'b1, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h24, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h24, 1'b1, 8'h04, 3'd2, 1'b1, 8'h04, 1'b1);
    add(1'b0, 8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 8'h20, 1'b1);
    add(1'b0, 8'h01, 1'b1, 8'h00, 3'd5, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 8'h00, 1'b1);
    add(1'b0, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 8'h01, 1'b1);
    add(1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
    // requester 3 stalled five cycles by the consumer
    add(1'b0, 8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) add(1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 8'h00, 1'b1);
    add(1'b0, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 8'h08, 1'b1);
    add(1'b0, 8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 8'h00, 1'b0);
    // requester 6 aborts; the following pick from ptr=4 proves ptr did not move
    add(1'b0, 8'h40, 1'b0, 8'h00, 3'd3, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 8'h00, 1'b1);
    add(1'b0, 8'h00, 1'b0, 8'h40, 3'd6, 1'b1, 8'h00, 1'b1);
    add(1'b0, 8'h00, 1'b1, 8'h00, 3'd6, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h21, 1'b0, 8'h00, 3'd6, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h21, 1'b1, 8'h20, 3'd5, 1'b1, 8'h20, 1'b1);
    add(1'b0, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 8'h01, 1'b1);
    add(1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
    // reset while granted: no ack, grant dropped, ptr back to 0
    add(1'b0, 8'h04, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 8'h00, 1'b1);
    add(1'b1, 8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 8'h00, 1'b1);
    add(1'b0, 8'h04, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 8'h04, 1'b1);
    add(1'b0, 8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 8'h00, 1'b0);

    next_cycle();
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; req = vecs[i].req; out_ready = vecs[i].rdy;
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].valid,
                 vecs[i].ack, vecs[i].busy);
      next_cycle();
    end

    // full rotation with every requester active
    reset = 1'b1; req = 8'h00; out_ready = 1'b1;
    next_cycle();
    reset = 1'b0; req = 8'hFF;
    @(negedge clk);
    check_outs("rot idle", 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
    next_cycle();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check_outs($sformatf("rot%0d", k), 8'h01 << (k % 8), 3'(k % 8), 1'b1,
                 8'h01 << (k % 8), 1'b1);
      next_cycle();
    end

    // two requesters, requester 0 asking to lock
`ifdef ARB_LOCK_EN
    exp_owner = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    lock = 8'h01;
`else
    exp_owner = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif
    reset = 1'b1; req = 8'h00;
    next_cycle();
    reset = 1'b0; req = 8'h03;
    @(negedge clk);
    check_outs("lock idle", 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
    next_cycle();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_outs($sformatf("lock%0d", k), 8'h01 << exp_owner[k], 3'(exp_owner[k]), 1'b1,
                 8'h01 << exp_owner[k], 1'b1);
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
